unit_wb_buffer: RTL and testbench

Writeback-side transmitter for fixed-latency functional units such as the multiplier. It accepts results from the unit's pipeline and holds them in an in-order circular buffer. It presents the oldest result on the unit writeback interface until the writeback stage accepts it. A credit count back-pressures issue so that no result can be lost, whatever the writeback acceptance latency.

---
 rtl/unit_wb_buffer_pkg.sv | 11 +
 rtl/unit_wb_buffer_if.sv | 21 ++
 rtl/unit_wb_buffer_storage.sv | 27 ++
 rtl/unit_wb_buffer.sv | 96 +++++++++
 tb/tb_unit_wb_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/unit_wb_buffer_pkg.sv
// Shared types for the unit writeback buffer: result width and the buffered entry layout.
package unit_wb_buffer_pkg;

  localparam int unsigned XLEN = 32;

  // Extension point: later fields (e.g. id) are added here and flow through storage unchanged.
  typedef struct packed {
    logic [XLEN-1:0] rd;
  } wb_buffer_entry_t;

endpackage

// File: rtl/unit_wb_buffer_if.sv
// Unit-to-writeback handshake: the unit presents a result, writeback signals acceptance.
interface unit_wb_buffer_if;
  import unit_wb_buffer_pkg::*;

  logic            done_next_cycle;
  logic [XLEN-1:0] rd;
  logic            accepted;

  modport master (
    output done_next_cycle,
    output rd,
    input  accepted
  );

  modport slave (
    input  done_next_cycle,
    input  rd,
    output accepted
  );

endinterface

// File: rtl/unit_wb_buffer_storage.sv
// Result storage: one synchronous write port at tail, one asynchronous read port at head.
module unit_wb_buffer_storage
  import unit_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PtrW-1:0]  waddr,
  input  wb_buffer_entry_t wdata,
  input  logic [PtrW-1:0]  raddr,
  output wb_buffer_entry_t rdata
);

  // No reset on the array: occupancy is tracked by the parent, so stale contents are never exposed.
  wb_buffer_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/unit_wb_buffer.sv
// Writeback-side transmitter for fixed-latency units: in-order result buffer with credit-based
// issue back-pressure so no result is ever dropped regardless of writeback acceptance latency.
module unit_wb_buffer
  import unit_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_new_request,
  output logic             issue_ready,
  input  logic             result_valid,
  input  logic [XLEN-1:0]  result_data,
  unit_wb_buffer_if.master wb,
  output logic             protocol_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  logic [CntW-1:0] in_flight_q, in_flight_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic            err_q, err_d;

  logic             issue_fire, result_ok, result_err, pop, pop_err, has_data;
  logic [CntW:0]    credits_used;
  wb_buffer_entry_t head_entry;
  wb_buffer_entry_t write_entry;

  // Every issued-but-unaccepted op holds a credit until its result is popped.
  assign credits_used = {1'b0, in_flight_q} + {1'b0, count_q};
  assign issue_ready  = ~rst & (credits_used < DepthLim);

  assign has_data   = (count_q != '0);
  assign issue_fire = issue_new_request & issue_ready;
  assign result_ok  = result_valid & (in_flight_q != '0);
  assign result_err = result_valid & (in_flight_q == '0);
  assign pop        = wb.accepted & has_data;
  assign pop_err    = wb.accepted & ~has_data;

  always_comb begin
    in_flight_d = in_flight_q;
    count_d     = count_q;
    if (issue_fire && !result_ok) begin
      in_flight_d = in_flight_q + CntW'(1);
    end else if (!issue_fire && result_ok) begin
      in_flight_d = in_flight_q - CntW'(1);
    end
    if (result_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!result_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
    head_d = head_q + PtrW'(pop);
    tail_d = tail_q + PtrW'(result_ok);
    err_d  = err_q | result_err | pop_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
    end
  end

  assign write_entry = '{rd: result_data};

  unit_wb_buffer_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (result_ok),
    .waddr (tail_q),
    .wdata (write_entry),
    .raddr (head_q),
    .rdata (head_entry)
  );

  // Masked when empty so unwritten or stale slots never reach writeback.
  assign wb.done_next_cycle = has_data;
  assign wb.rd              = has_data ? head_entry.rd : '0;
  assign protocol_err       = err_q;

endmodule

// File: tb/tb_unit_wb_buffer.sv
// Directed self-checking bench for unit_wb_buffer: per-cycle vector table plus hand-written
// sequences for full-buffer simultaneous result/pop, protocol errors and mid-operation reset.
module tb_unit_wb_buffer;
  import unit_wb_buffer_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_new_request = 1'b0;
  logic            issue_ready;
  logic            result_valid = 1'b0;
  logic [XLEN-1:0] result_data = '0;
  logic            protocol_err;

  int checks = 0;
  int errors = 0;

  unit_wb_buffer_if wb_if ();

  unit_wb_buffer #(
    .DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_new_request (issue_new_request),
    .issue_ready       (issue_ready),
    .result_valid      (result_valid),
    .result_data       (result_data),
    .wb                (wb_if),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  // One row per cycle: inputs held for the cycle, outputs expected during it (before the edge).
  typedef struct {
    logic        r;
    logic        iss;
    logic        rv;
    logic [31:0] d;
    logic        acc;
    logic        e_ready;
    logic        e_done;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iss, logic rv, logic [31:0] d, logic acc,
                              logic e_ready, logic e_done, logic [31:0] e_rd, logic e_err);
    vec_t v;
    v.r = r; v.iss = iss; v.rv = rv; v.d = d; v.acc = acc;
    v.e_ready = e_ready; v.e_done = e_done; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic iss, logic rv, logic [31:0] d, logic acc);
    @(posedge clk);
    #1;
    rst               = r;
    issue_new_request = iss;
    result_valid      = rv;
    result_data       = d;
    wb_if.accepted    = acc;
  endtask

  task automatic expect_out(string nm, logic e_ready, logic e_done, logic [31:0] e_rd,
                            logic e_err);
    @(negedge clk);
    chk({nm, ".issue_ready"}, {31'b0, issue_ready}, {31'b0, e_ready});
    chk({nm, ".done"}, {31'b0, wb_if.done_next_cycle}, {31'b0, e_done});
    chk({nm, ".wb_rd"}, wb_if.rd, e_rd);
    chk({nm, ".protocol_err"}, {31'b0, protocol_err}, {31'b0, e_err});
  endtask

  initial begin
    wb_if.accepted = 1'b0;

    //                r  iss rv data          acc  rdy done rd            err
    vecs.push_back(mk(1, 0, 0, 32'h0,         0,   0,  0,   32'h0,        0));
    // Single op: issue, result two cycles later, visible next cycle, accepted later.
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_1200, 0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   1,  1,   32'h0000_1200, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   1,  1,   32'h0000_1200, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'h0000_1200, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    // Credit exhaustion: four issues, a fifth request is refused.
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   0,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'h1,         0,   0,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'h2,         0,   0,  1,   32'h1,        0));
    vecs.push_back(mk(0, 0, 1, 32'h3,         0,   0,  1,   32'h1,        0));
    vecs.push_back(mk(0, 0, 1, 32'h4,         0,   0,  1,   32'h1,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   0,  1,   32'h1,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   0,  1,   32'h1,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'h2,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'h3,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'h4,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    // Back-to-back drain of A..D with accept held high.
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   1,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'hA,         0,   0,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'hB,         0,   0,  1,   32'hA,        0));
    vecs.push_back(mk(0, 0, 1, 32'hC,         0,   0,  1,   32'hA,        0));
    vecs.push_back(mk(0, 0, 1, 32'hD,         0,   0,  1,   32'hA,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   0,  1,   32'hA,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'hB,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'hC,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,   1,  1,   32'hD,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,   1,  0,   32'h0,        0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].iss, vecs[i].rv, vecs[i].d, vecs[i].acc);
      expect_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_done, vecs[i].e_rd,
                 vecs[i].e_err);
    end

    // Full buffer, then a pop frees a credit whose result lands on the same edge as the next pop.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 0);
      expect_out("full.issue", 1, 0, 32'h0, 0);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 32'(i), 0);
      expect_out("full.result", 0, (i > 1), (i > 1) ? 32'h1 : 32'h0, 0);
    end
    drive(0, 0, 0, 32'h0, 1);
    expect_out("full.pop1", 0, 1, 32'h1, 0);
    drive(0, 1, 0, 32'h0, 0);
    expect_out("full.reissue", 1, 1, 32'h2, 0);
    drive(0, 0, 1, 32'h5, 1);
    expect_out("full.simul", 0, 1, 32'h2, 0);
    drive(0, 0, 0, 32'h0, 1);
    expect_out("full.order3", 1, 1, 32'h3, 0);
    drive(0, 0, 0, 32'h0, 1);
    expect_out("full.order4", 1, 1, 32'h4, 0);
    drive(0, 0, 0, 32'h0, 1);
    expect_out("full.order5", 1, 1, 32'h5, 0);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("full.empty", 1, 0, 32'h0, 0);

    // Accept on an empty buffer: sticky error, no state change.
    drive(0, 0, 0, 32'h0, 1);
    expect_out("err.acc_empty", 1, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("err.acc_flag", 1, 0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("err.sticky", 1, 0, 32'h0, 1);
    drive(1, 0, 0, 32'h0, 0);
    expect_out("err.rst", 0, 0, 32'h0, 1);
    // Result with nothing in flight: dropped and flagged.
    drive(0, 0, 1, 32'h55, 0);
    expect_out("err.rv_noflight", 1, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("err.rv_flag", 1, 0, 32'h0, 1);
    drive(1, 0, 0, 32'h0, 0);
    expect_out("err.rst2", 0, 0, 32'h0, 1);

    // Reset mid-operation with three buffered results and one still in flight.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 0);
      expect_out("mid.issue", 1, 0, 32'h0, 0);
    end
    drive(0, 0, 1, 32'h11, 0);
    expect_out("mid.r1", 0, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h22, 0);
    expect_out("mid.r2", 0, 1, 32'h11, 0);
    drive(0, 0, 1, 32'h33, 0);
    expect_out("mid.r3", 0, 1, 32'h11, 0);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("mid.held", 0, 1, 32'h11, 0);
    drive(1, 0, 0, 32'h0, 0);
    expect_out("mid.rst", 0, 1, 32'h11, 0);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("mid.after", 1, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h44, 0);
    expect_out("mid.stale_rv", 1, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 1);
    expect_out("mid.stale_flag", 1, 0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 0);
    expect_out("mid.no_wb", 1, 0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
